// File: rtl/d_bch_sc_dispatch_x.sv
// d_bch_sc_dispatch_x
// Slices a page-wide byte stream into fixed-size chunks, streams each chunk to
// the next syndrome lane in round-robin order, and reports lane completions
// upstream strictly in chunk order, followed by one page-complete pulse.
//
// Ports:
//   i_clk, i_RESET                  clock, asynchronous active-low reset
//   i_exe_sc, i_chunk_count         page start pulse and chunk count (0 = ignore)
//   i_code_valid, i_code            upstream stream in
//   o_code_ready                    upstream ready
//   o_lane_valid/code/first/last/chunk, i_lane_ready   per-lane stream out
//   i_lane_cmplt, i_lane_error      per-lane completion and error flag
//   o_sc_available                  lane idle (nothing outstanding, no pending result)
//   o_page_busy                     page in progress
//   o_chunk_done/_num, o_chunk_error  in-order chunk report
//   o_page_cmplt, o_page_error      page completion and OR of chunk errors
module d_bch_sc_dispatch_x #(
    parameter int unsigned Multi      = 4,
    parameter int unsigned DW         = 8,
    parameter int unsigned ChunkBytes = 256,
    parameter int unsigned CNW        = 5
) (
    input  logic                 i_clk,
    input  logic                 i_RESET,
    input  logic                 i_exe_sc,
    input  logic [CNW-1:0]       i_chunk_count,
    input  logic                 i_code_valid,
    input  logic [DW-1:0]        i_code,
    output logic                 o_code_ready,
    output logic [Multi-1:0]     o_lane_valid,
    output logic [DW*Multi-1:0]  o_lane_code,
    output logic [Multi-1:0]     o_lane_first,
    output logic [Multi-1:0]     o_lane_last,
    output logic [CNW*Multi-1:0] o_lane_chunk,
    input  logic [Multi-1:0]     i_lane_ready,
    input  logic [Multi-1:0]     i_lane_cmplt,
    input  logic [Multi-1:0]     i_lane_error,
    output logic [Multi-1:0]     o_sc_available,
    output logic                 o_page_busy,
    output logic                 o_chunk_done,
    output logic [CNW-1:0]       o_chunk_done_num,
    output logic                 o_chunk_error,
    output logic                 o_page_cmplt,
    output logic                 o_page_error
);

    localparam int unsigned RrW = (Multi > 1) ? $clog2(Multi) : 1;
    localparam int unsigned BcW = $clog2(ChunkBytes);
    localparam logic [RrW-1:0] RrLast   = RrW'(Multi - 1);
    localparam logic [BcW-1:0] ByteLast = BcW'(ChunkBytes - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SELECT = 2'd1,
        S_STREAM = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNW-1:0]     count_q;
    logic [CNW-1:0]     chunk_q;
    logic [CNW-1:0]     rep_cnt_q;
    logic [BcW-1:0]     byte_q;
    logic [RrW-1:0]     rr_q;
    logic [RrW-1:0]     rp_q;
    logic [Multi-1:0]   outst_q;
    logic [Multi-1:0]   res_vld_q;
    logic [Multi-1:0]   res_err_q;
    logic [CNW-1:0]     tag_q [Multi];

    logic [Multi-1:0]   avail_c;
    logic               start_c;
    logic               xfer_c;
    logic               first_c;
    logic               last_c;
    logic               report_c;
    logic               drain_done_c;

    // A lane is reusable only once its previous chunk is finished and reported.
    assign avail_c      = ~outst_q & ~res_vld_q;
    assign start_c      = (state_q == S_IDLE) && i_exe_sc && (i_chunk_count != '0);
    assign xfer_c       = (state_q == S_STREAM) && i_code_valid && i_lane_ready[rr_q];
    assign first_c      = (byte_q == '0);
    assign last_c       = (byte_q == ByteLast);
    assign report_c     = res_vld_q[rp_q];
    assign drain_done_c = (state_q == S_DRAIN) && (rep_cnt_q == count_q);

    assign o_sc_available = avail_c;
    assign o_page_busy    = (state_q != S_IDLE);

    // State register
    always_ff @(posedge i_clk or negedge i_RESET) begin
        if (!i_RESET) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (start_c) state_d = S_SELECT;
            S_SELECT: if (avail_c[rr_q]) state_d = S_STREAM;
            S_STREAM: if (xfer_c && last_c)
                          state_d = ((chunk_q + CNW'(1)) == count_q) ? S_DRAIN : S_SELECT;
            S_DRAIN:  if (drain_done_c) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Zero-latency routing of the upstream stream to the selected lane
    always_comb begin
        o_code_ready = 1'b0;
        o_lane_valid = '0;
        o_lane_code  = '0;
        o_lane_first = '0;
        o_lane_last  = '0;
        o_lane_chunk = '0;
        if (state_q == S_STREAM) begin
            o_code_ready = i_lane_ready[rr_q];
            for (int k = 0; k < int'(Multi); k++) begin
                if (RrW'(k) == rr_q) begin
                    o_lane_valid[k]              = i_code_valid;
                    o_lane_code[k*DW +: DW]      = i_code;
                    o_lane_first[k]              = first_c;
                    o_lane_last[k]               = last_c;
                    o_lane_chunk[k*CNW +: CNW]   = chunk_q;
                end
            end
        end
    end

    // Dispatch counters, lane bookkeeping and in-order reporter
    always_ff @(posedge i_clk or negedge i_RESET) begin
        if (!i_RESET) begin
            count_q          <= '0;
            chunk_q          <= '0;
            rep_cnt_q        <= '0;
            byte_q           <= '0;
            rr_q             <= '0;
            rp_q             <= '0;
            outst_q          <= '0;
            res_vld_q        <= '0;
            res_err_q        <= '0;
            for (int k = 0; k < int'(Multi); k++) tag_q[k] <= '0;
            o_chunk_done     <= 1'b0;
            o_chunk_done_num <= '0;
            o_chunk_error    <= 1'b0;
            o_page_cmplt     <= 1'b0;
            o_page_error     <= 1'b0;
        end else begin
            if (start_c) begin
                count_q      <= i_chunk_count;
                chunk_q      <= '0;
                rep_cnt_q    <= '0;
                byte_q       <= '0;
                rr_q         <= '0;
                rp_q         <= '0;
                o_page_error <= 1'b0;
            end

            // Completions only count on lanes that actually hold a chunk.
            for (int k = 0; k < int'(Multi); k++) begin
                if (i_lane_cmplt[k] && outst_q[k]) begin
                    res_vld_q[k] <= 1'b1;
                    res_err_q[k] <= i_lane_error[k];
                    outst_q[k]   <= 1'b0;
                end
            end

            if (xfer_c) begin
                if (first_c) begin
                    outst_q[rr_q] <= 1'b1;
                    tag_q[rr_q]   <= chunk_q;
                end
                if (last_c) begin
                    byte_q  <= '0;
                    chunk_q <= chunk_q + CNW'(1);
                    rr_q    <= (rr_q == RrLast) ? '0 : rr_q + RrW'(1);
                end else begin
                    byte_q  <= byte_q + BcW'(1);
                end
            end

            o_chunk_done <= report_c;
            if (report_c) begin
                o_chunk_done_num <= tag_q[rp_q];
                o_chunk_error    <= res_err_q[rp_q];
                o_page_error     <= o_page_error | res_err_q[rp_q];
                res_vld_q[rp_q]  <= 1'b0;
                rp_q             <= (rp_q == RrLast) ? '0 : rp_q + RrW'(1);
                rep_cnt_q        <= rep_cnt_q + CNW'(1);
            end

            o_page_cmplt <= drain_done_c;
        end
    end

endmodule

// File: tb/tb_d_bch_sc_dispatch_x.sv
// Bench for d_bch_sc_dispatch_x: the reference model tracks the page as a flat
// byte count (chunk = n / CB, lane = chunk % M) and a per-chunk schedule of
// lane completions, and checks routing, flags and in-order reports against it.
module tb_d_bch_sc_dispatch_x;

    localparam int M   = 4;
    localparam int DW  = 8;
    localparam int CB  = 8;
    localparam int CNW = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_exe_sc;
    logic [CNW-1:0]    i_chunk_count;
    logic              i_code_valid;
    logic [DW-1:0]     i_code;
    logic              o_code_ready;
    logic [M-1:0]      o_lane_valid;
    logic [DW*M-1:0]   o_lane_code;
    logic [M-1:0]      o_lane_first;
    logic [M-1:0]      o_lane_last;
    logic [CNW*M-1:0]  o_lane_chunk;
    logic [M-1:0]      i_lane_ready;
    logic [M-1:0]      i_lane_cmplt;
    logic [M-1:0]      i_lane_error;
    logic [M-1:0]      o_sc_available;
    logic              o_page_busy;
    logic              o_chunk_done;
    logic [CNW-1:0]    o_chunk_done_num;
    logic              o_chunk_error;
    logic              o_page_cmplt;
    logic              o_page_error;

    int tests_run    = 0;
    int tests_failed = 0;

    int        dly [32];
    bit [31:0] err_mask;
    bit        rand_mode;

    always #5 clk = ~clk;

    d_bch_sc_dispatch_x #(.Multi(M), .DW(DW), .ChunkBytes(CB), .CNW(CNW)) dut (
        .i_clk            (clk),
        .i_RESET          (rst_n),
        .i_exe_sc         (i_exe_sc),
        .i_chunk_count    (i_chunk_count),
        .i_code_valid     (i_code_valid),
        .i_code           (i_code),
        .o_code_ready     (o_code_ready),
        .o_lane_valid     (o_lane_valid),
        .o_lane_code      (o_lane_code),
        .o_lane_first     (o_lane_first),
        .o_lane_last      (o_lane_last),
        .o_lane_chunk     (o_lane_chunk),
        .i_lane_ready     (i_lane_ready),
        .i_lane_cmplt     (i_lane_cmplt),
        .i_lane_error     (i_lane_error),
        .o_sc_available   (o_sc_available),
        .o_page_busy      (o_page_busy),
        .o_chunk_done     (o_chunk_done),
        .o_chunk_done_num (o_chunk_done_num),
        .o_chunk_error    (o_chunk_error),
        .o_page_cmplt     (o_page_cmplt),
        .o_page_error     (o_page_error)
    );

    task automatic idle_inputs();
        i_exe_sc      = 1'b0;
        i_chunk_count = '0;
        i_code_valid  = 1'b0;
        i_code        = '0;
        i_lane_ready  = '1;
        i_lane_cmplt  = '0;
        i_lane_error  = '0;
    endtask

    // Runs one page of cnt chunks against the model. Stops early once abort_at
    // bytes have been accepted (abort_at >= 0). stall_obs counts cycles where
    // lane 1 sees valid data but upstream is held off.
    task automatic run_page(input int cnt, input int abort_at, input bit stall_en,
                            output int stall_obs);
        int  sent, rep_idx, stall_left, ch, pos, ln;
        int  cmplt_cyc [32];
        int  rep_cyc [32];
        bit  done, perr;
        logic [M-1:0] exp_vld;
        sent = 0; rep_idx = 0; stall_left = 0; stall_obs = 0; done = 0; perr = 0;
        for (int c = 0; c < 32; c++) begin
            cmplt_cyc[c] = -1;
            rep_cyc[c]   = -1;
            if (c < cnt && err_mask[c]) perr = 1;
        end
        @(negedge clk);
        i_exe_sc      = 1'b1;
        i_chunk_count = CNW'(cnt);
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            @(negedge clk);
            i_code_valid = (sent < cnt*CB) && (!rand_mode || $urandom_range(0, 3) != 0);
            i_code       = DW'($urandom);
            for (int j = 0; j < M; j++)
                i_lane_ready[j] = !rand_mode || ($urandom_range(0, 3) != 0);
            if (stall_left > 0) begin
                i_lane_ready[1] = 1'b0;
                stall_left--;
            end
            i_lane_cmplt = '0;
            i_lane_error = '0;
            for (int c = 0; c < cnt; c++) begin
                if (cmplt_cyc[c] == cyc) begin
                    i_lane_cmplt[c % M] = 1'b1;
                    i_lane_error[c % M] = err_mask[c];
                end
            end
            // Start pulses while the page is running must be ignored.
            i_exe_sc      = (sent < cnt*CB) && ($urandom_range(0, 7) == 0);
            i_chunk_count = CNW'($urandom_range(0, 31));
            #1;
            if (o_chunk_done) begin
                tests_run++;
                if (rep_idx >= cnt || o_chunk_done_num !== CNW'(rep_idx)) begin
                    tests_failed++;
                    $display("FAIL report_order: got chunk %0d, required chunk %0d", o_chunk_done_num, rep_idx);
                end
                tests_run++;
                if (rep_idx < cnt && o_chunk_error !== err_mask[rep_idx]) begin
                    tests_failed++;
                    $display("FAIL report_error: chunk %0d got %0b, required %0b", rep_idx, o_chunk_error, err_mask[rep_idx]);
                end
                tests_run++;
                if (rep_idx < cnt && (cmplt_cyc[rep_idx] < 0 || cmplt_cyc[rep_idx] >= cyc)) begin
                    tests_failed++;
                    $display("FAIL report_early: chunk %0d reported at cycle %0d, completion cycle %0d", rep_idx, cyc, cmplt_cyc[rep_idx]);
                end
                if (rep_idx < 32) rep_cyc[rep_idx] = cyc;
                rep_idx++;
            end
            if (o_page_cmplt) begin
                done = 1;
                tests_run++;
                if (rep_idx !== cnt || sent !== cnt*CB) begin
                    tests_failed++;
                    $display("FAIL page_count: reports %0d bytes %0d, required %0d and %0d", rep_idx, sent, cnt, cnt*CB);
                end
                tests_run++;
                if (o_page_error !== perr) begin
                    tests_failed++;
                    $display("FAIL page_error: got %0b, required %0b", o_page_error, perr);
                end
                tests_run++;
                if (o_page_busy !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL page_busy_end: got %0b, required 0", o_page_busy);
                end
            end
            if (stall_en && o_lane_valid[1] && !o_code_ready) stall_obs++;
            if (i_code_valid && o_code_ready) begin
                ch      = sent / CB;
                pos     = sent % CB;
                ln      = ch % M;
                exp_vld = M'(1 << ln);
                tests_run++;
                if (o_lane_valid !== exp_vld || o_lane_code[ln*DW +: DW] !== i_code) begin
                    tests_failed++;
                    $display("FAIL route: byte %0d valid %b data %h, required valid %b data %h",
                             sent, o_lane_valid, o_lane_code[ln*DW +: DW], exp_vld, i_code);
                end
                tests_run++;
                if (o_lane_first !== (pos == 0 ? exp_vld : '0) ||
                    o_lane_last !== (pos == CB-1 ? exp_vld : '0)) begin
                    tests_failed++;
                    $display("FAIL flags: byte %0d first %b last %b, required pos %0d of lane %0d",
                             sent, o_lane_first, o_lane_last, pos, ln);
                end
                tests_run++;
                if (o_lane_chunk[ln*CNW +: CNW] !== CNW'(ch)) begin
                    tests_failed++;
                    $display("FAIL lane_chunk: byte %0d got %0d, required %0d", sent, o_lane_chunk[ln*CNW +: CNW], ch);
                end
                if (pos == 0 && ch >= M) begin
                    tests_run++;
                    if (rep_cyc[ch-M] < 0 || rep_cyc[ch-M] >= cyc) begin
                        tests_failed++;
                        $display("FAIL lane_reuse: chunk %0d started at cycle %0d, chunk %0d report cycle %0d",
                                 ch, cyc, ch-M, rep_cyc[ch-M]);
                    end
                end
                if (pos == CB-1) begin
                    tests_run++;
                    if (o_sc_available[ln] !== 1'b0) begin
                        tests_failed++;
                        $display("FAIL outstanding: lane %0d available %0b, required 0", ln, o_sc_available[ln]);
                    end
                    cmplt_cyc[ch] = cyc + dly[ch];
                end
                if (stall_en && ch == 1 && pos == 3) stall_left = 5;
                sent++;
            end
            if (abort_at >= 0 && sent >= abort_at) return;
        end
        if (!done && abort_at < 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL page_timeout: no page complete after 3000 cycles, reports %0d of %0d", rep_idx, cnt);
        end
        i_exe_sc     = 1'b0;
        i_code_valid = 1'b0;
        i_lane_cmplt = '0;
    endtask

    task automatic set_defaults();
        for (int c = 0; c < 32; c++) dly[c] = 1;
        err_mask  = '0;
        rand_mode = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        tests_run++;
        if (o_sc_available !== '1) begin
            tests_failed++;
            $display("FAIL reset_avail: got %b, required 1111", o_sc_available);
        end
        tests_run++;
        if ({o_code_ready, o_lane_valid, o_lane_code, o_lane_first, o_lane_last, o_lane_chunk,
             o_page_busy, o_chunk_done, o_chunk_done_num, o_chunk_error, o_page_cmplt, o_page_error} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: busy %0b ready %0b done %0b cmplt %0b err %0b, required all 0",
                     o_page_busy, o_code_ready, o_chunk_done, o_page_cmplt, o_page_error);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int so;
        set_defaults();
        run_page(4, -1, 0, so);
    endtask

    task automatic test_select_stall();
        int so;
        set_defaults();
        dly[0] = 20;
        dly[1] = 25;
        run_page(6, -1, 0, so);
    endtask

    task automatic test_out_of_order();
        int so;
        set_defaults();
        dly[0] = 25; dly[1] = 40; dly[2] = 1; dly[3] = 2;
        err_mask = 32'h4;
        run_page(4, -1, 0, so);
        repeat (3) @(negedge clk);
        #1;
        tests_run++;
        if (o_page_error !== 1'b1) begin
            tests_failed++;
            $display("FAIL page_error_hold: got %0b, required 1", o_page_error);
        end
    endtask

    task automatic test_ready_stall();
        int so;
        set_defaults();
        run_page(4, -1, 1, so);
        tests_run++;
        if (so !== 5) begin
            tests_failed++;
            $display("FAIL ready_stall: held off %0d cycles, required 5", so);
        end
    endtask

    task automatic test_ignored();
        int so;
        set_defaults();
        @(negedge clk);
        i_exe_sc      = 1'b1;
        i_chunk_count = '0;
        @(negedge clk);
        i_exe_sc = 1'b0;
        #1;
        tests_run++;
        if (o_page_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_count: busy %0b, required 0", o_page_busy);
        end
        i_lane_cmplt = 4'b1000;
        i_lane_error = 4'b1000;
        @(negedge clk);
        i_lane_cmplt = '0;
        i_lane_error = '0;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++;
            if (o_chunk_done !== 1'b0 || o_sc_available !== '1) begin
                tests_failed++;
                $display("FAIL spurious_cmplt: done %0b avail %b, required 0 and 1111", o_chunk_done, o_sc_available);
            end
            @(negedge clk);
        end
        // A page with start pulses injected during STREAM still completes with its own count.
        run_page(2, -1, 0, so);
    endtask

    task automatic test_mid_reset();
        int so;
        set_defaults();
        run_page(4, 2*CB + 3, 0, so);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (o_sc_available !== '1 || o_page_busy !== 1'b0 || o_lane_valid !== '0 ||
            o_code_ready !== 1'b0 || o_chunk_done !== 1'b0 || o_page_cmplt !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset: avail %b busy %0b lane_valid %b ready %0b, required 1111 0 0000 0",
                     o_sc_available, o_page_busy, o_lane_valid, o_code_ready);
        end
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        run_page(1, -1, 0, so);
    endtask

    task automatic test_random();
        int so, cnt;
        for (int p = 0; p < 3; p++) begin
            set_defaults();
            rand_mode = 1;
            cnt = $urandom_range(1, 12);
            for (int c = 0; c < 32; c++) dly[c] = $urandom_range(1, 30);
            err_mask = $urandom;
            run_page(cnt, -1, 0, so);
            repeat (2) @(negedge clk);
        end
    endtask

    initial begin
        idle_inputs();
        set_defaults();
        rst_n = 1'b0;
        test_reset();
        test_basic();
        test_select_stall();
        test_out_of_order();
        test_ready_stall();
        test_ignored();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/d_bch_sc_dispatch_x.md
Name: d_bch_sc_dispatch_x

Overview:
- Front-end chunk dispatcher for a parametrised bank of Multi syndrome-calculator lanes.
- Accepts one page-wide byte stream, slices it into fixed-size chunks and streams each whole chunk to the next lane in round-robin order.
- Lanes are handshaked independently; lane completions are collected and reported upstream strictly in chunk order, followed by one page-complete pulse.
- Sits between the NAND data path and the syndrome lanes, ahead of the error-locator stage.

Parameters:
- Multi, 4, number of syndrome lanes (1..8).
- DW, 8, code bits per transfer.
- ChunkBytes, 256, transfers per chunk (>=2).
- CNW, 5, chunk-number width; at most 2^CNW-1 chunks per page.

Ports:
- i_clk  input  1  clock.
- i_RESET  input  1  asynchronous reset, active-low.
- i_exe_sc  input  1  page start pulse; sampled only in IDLE.
- i_chunk_count  input  CNW  chunks in the page, sampled with i_exe_sc; 0 = start ignored.
- i_code_valid  input  1  upstream data valid.
- i_code  input  DW  upstream code data.
- o_code_ready  output  1  upstream ready.
- o_lane_valid  output  Multi  per-lane data valid.
- o_lane_code  output  DW*Multi  per-lane data; lane k at [(k+1)*DW-1:k*DW].
- o_lane_first  output  Multi  first transfer of a chunk.
- o_lane_last  output  Multi  last transfer of a chunk.
- o_lane_chunk  output  CNW*Multi  chunk number of the current lane transfer.
- i_lane_ready  input  Multi  per-lane ready.
- i_lane_cmplt  input  Multi  lane syndrome-complete pulse.
- i_lane_error  input  Multi  lane error flag, valid with i_lane_cmplt.
- o_sc_available  output  Multi  lane has no outstanding chunk.
- o_page_busy  output  1  page in progress.
- o_chunk_done  output  1  in-order chunk report pulse.
- o_chunk_done_num  output  CNW  chunk number of the report.
- o_chunk_error  output  1  error flag of the reported chunk.
- o_page_cmplt  output  1  page-complete pulse.
- o_page_error  output  1  OR of all chunk errors in the page; valid with o_page_cmplt.

Behaviour:
- Reset (i_RESET=0, async):
  - state IDLE; all counters and pointers 0; all lane outstanding and result flags cleared.
  - o_sc_available all 1; every other output 0.
- Transfers: a transfer occurs when valid & ready are both high at a rising edge.
- FSM states: IDLE, SELECT, STREAM, DRAIN.
- IDLE:
  - i_exe_sc=1 with i_chunk_count!=0 latches the count, clears the page error and pointers, and goes to SELECT next cycle.
  - o_page_busy=1 in every state except IDLE.
- SELECT:
  - Waits until the lane at dispatch pointer rr is available, then goes to STREAM next cycle.
  - o_code_ready=0.
- STREAM (combinational routing, zero latency):
  - o_lane_valid[rr]=i_code_valid; o_lane_code[rr]=i_code; o_code_ready=i_lane_ready[rr].
  - All other lanes see valid 0.
  - o_lane_first[rr]=1 while byte counter=0; o_lane_last[rr]=1 while byte counter=ChunkBytes-1.
  - o_lane_chunk[rr]=current chunk number.
  - The first transfer clears o_sc_available[rr] (marks the lane outstanding) and records the chunk number in lane rr's tag.
  - On the last transfer: byte counter←0, chunk number+1, rr←(rr+1) mod Multi. Go to DRAIN if the chunk number reaches the count, otherwise to SELECT.
- Lane completion:
  - i_lane_cmplt[k] on an outstanding lane stores result-valid and the error flag, then clears outstanding (sets o_sc_available[k]) in the same edge.
  - i_lane_cmplt on a non-outstanding lane is ignored.
  - Several lanes may complete in the same cycle; all are captured.
  - A lane is reusable only after its result has been reported: availability requires not outstanding and no pending result.
- In-order reporter:
  - Report pointer rp walks lanes round-robin from lane 0.
  - When lane rp holds a result, the next cycle drives a registered o_chunk_done=1 with the lane tag and error flag, clears the result, advances rp and ORs the error into o_page_error.
  - At most one report per cycle.
- DRAIN:
  - When reported count = chunk count, o_page_cmplt=1 for one cycle with o_page_error, then IDLE.
  - o_page_error holds its value until the next accepted i_exe_sc.
- Simultaneous events:
  - i_exe_sc outside IDLE is ignored.
  - Completion and report on the same lane in the same cycle are both honoured.
- Reset mid-page aborts immediately with no reports; upstream data in flight is dropped.

Test Plan:
- Multi=4, ChunkBytes=8, count=4, all lanes ready, lanes complete in order 0..3 with no errors -> bytes 0-7 go to lane0, 8-15 to lane1, ..., 24-31 to lane3; first/last flags on bytes 0/7 of each chunk; o_chunk_done_num 0,1,2,3; o_page_cmplt=1 with o_page_error=0.
- count=6 on 4 lanes -> chunks 4 and 5 stall in SELECT until lanes 0 and 1 have completed and been reported; chunk 4 goes to lane0 and chunk 5 to lane1.
- Lanes complete in order 2,0,3,1, lane2 with error=1 -> reports still in order 0,1,2,3; chunk 2 reported with o_chunk_error=1; o_page_error=1.
- i_lane_ready[1] low for 5 cycles mid-chunk 1 -> o_code_ready low for exactly those 5 cycles; no byte lost or duplicated.
- i_exe_sc with count=0, then i_exe_sc during STREAM -> both ignored; a spurious i_lane_cmplt[3] in IDLE leaves no report.
- Reset asserted low during chunk 2 -> all outputs return to reset values immediately; a new page with count=1 then completes normally.
